// File: rtl/dm_resp.sv
// Fixed-latency data-memory responder: accepts one request, completes it LATENCY edges later.
// Define DM_BYTEWR_EN for byte-lane writes (err only when be==0); default is word writes, err on misalignment.
module dm_resp #(
   parameter int LATENCY = 2,
   parameter int AW      = 7
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);
   localparam int DEPTH = 1 << AW;

   // Handshake: req is sampled only in IDLE; ready is a one-cycle pulse in DONE,
   // err/rdata are meaningful while ready=1, busy spans acceptance through DONE.
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            accept, enter_done, txn_err;
   logic            we_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            c_we;
   logic [AW-1:0]   c_idx;
   logic [31:0]     c_wdata;
   logic            unused_bits;
   logic [31:0]     mem [DEPTH];

`ifdef DM_BYTEWR_EN
   logic [3:0]      be_q;
   logic [3:0]      c_be;
`else
   logic [1:0]      off_q;
   logic [1:0]      c_off;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE: if (req) begin
            accept    = 1'b1;
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = (LATENCY == 1) ? DONE : WAIT;
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // DONE always exits to IDLE, so a DONE next-state means we are entering it.
   assign enter_done = (state_nxt == DONE);

   // With LATENCY=1 completion happens on the accepting edge, before the latches load.
   assign c_we    = accept ? we               : we_q;
   assign c_idx   = accept ? addr[AW+1:2]     : idx_q;
   assign c_wdata = accept ? wdata            : wdata_q;

`ifdef DM_BYTEWR_EN
   assign c_be        = accept ? be : be_q;
   assign txn_err     = (c_be == 4'b0000);
   assign unused_bits = ^{addr[31:AW+2], addr[1:0]};
`else
   assign c_off       = accept ? addr[1:0] : off_q;
   assign txn_err     = (c_off != 2'b00);
   assign unused_bits = ^{addr[31:AW+2], be};
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err   <= enter_done && txn_err;
         if (accept) begin
            we_q    <= we;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
`ifdef DM_BYTEWR_EN
            be_q    <= be;
`else
            off_q   <= addr[1:0];
`endif
         end
         if (enter_done) begin
            if (txn_err)    rdata <= '0;
            else if (!c_we) rdata <= mem[c_idx];
         end
      end
   end

   // Storage has no reset; a reset on the completing edge cancels the write.
   always_ff @(posedge clk) begin
      if (rstn && enter_done && c_we && !txn_err) begin
`ifdef DM_BYTEWR_EN
         for (int i = 0; i < 4; i++)
            if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
`else
         mem[c_idx] <= c_wdata;
`endif
      end
   end

   assign ready = (state == DONE);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: transaction-level memory model, per-cycle compare, directed and random traffic.
module tb_dm_resp;
   localparam int LAT   = 2;
   localparam int AW    = 7;
   localparam int DEPTH = 1 << AW;

   // clock / reset
   logic clk = 1'b0, rstn = 1'b0, req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic [31:0] rdata;
   logic        ready, busy, err;

   always #5 clk = ~clk;

   dm_resp #(.LATENCY(LAT), .AW(AW)) dut (
      .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .be(be),
      .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: memory array plus the transaction in flight, counted in edges since acceptance
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   bit          m_inflight = 1'b0;
   int          m_es = 0;
   bit          chk_en = 1'b0;
   bit          t_we, t_err = 1'b0;
   logic [31:0] t_addr, t_wdata;
   logic [3:0]  t_be;
   logic [31:0] e_rdata = '0;
   bit          e_rdata_known = 1'b1;
   bit          e_ready;

   task automatic model_complete();
      int idx;
      idx = int'((t_addr >> 2) % DEPTH);
`ifdef DM_BYTEWR_EN
      t_err = (t_be == 4'b0000);
`else
      t_err = (t_addr % 4) != 0;
`endif
      if (t_err) begin
         e_rdata = '0;
         e_rdata_known = 1'b1;
      end else if (t_we) begin
`ifdef DM_BYTEWR_EN
         for (int b = 0; b < 4; b++)
            if (t_be[b]) m_mem[idx][8*b +: 8] = t_wdata[8*b +: 8];
         if (t_be == 4'hF) m_known[idx] = 1'b1;
`else
         m_mem[idx] = t_wdata;
         m_known[idx] = 1'b1;
`endif
      end else begin
         e_rdata = m_mem[idx];
         e_rdata_known = m_known[idx];
      end
   endtask

   always @(posedge clk) begin
      if (!rstn) begin
         m_inflight = 1'b0;
         m_es = 0;
         t_err = 1'b0;
         e_rdata = '0;
         e_rdata_known = 1'b1;
         chk_en = 1'b1;
      end else if (m_inflight) begin
         m_es++;
         if (m_es == LAT) m_inflight = 1'b0;
         else if (m_es == LAT - 1) model_complete();
      end else if (req) begin
         m_inflight = 1'b1;
         m_es = 0;
         t_we = we; t_addr = addr; t_wdata = wdata; t_be = be;
         if (LAT == 1) model_complete();
      end
   end

   // scoreboard compare on the inactive edge
   always @(negedge clk) begin
      if (chk_en) begin
         e_ready = m_inflight && (m_es == LAT - 1);
         check("ready", 32'(ready), 32'(e_ready));
         check("busy", 32'(busy), 32'(m_inflight));
         if (e_ready) check("err", 32'(err), 32'(t_err));
         if (e_rdata_known) check("rdata", rdata, e_rdata);
      end
   end

   // driver: one transaction from IDLE, returns rdata/err seen with ready
   task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] r, output bit e);
      int n;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(posedge clk);
      n = 1;
      #1;
      req = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      be = 4'($urandom_range(0, 15));
      while (!ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 32'(n), 32'(LAT));
      r = rdata;
      e = err;
      @(posedge clk);
      #1;
   endtask

   // write whose completing edge is replaced by a reset edge
   task automatic aborted_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = 4'hF;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (LAT - 2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready", 32'(ready), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdata", rdata, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, a, d;
      bit          e;
      int          n_rdy;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      check("rst_rdata", rdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);

      for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, r, e);

      // write then read back
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e);
      check("wr10_err", 32'(e), 32'd0);
      txn(1'b0, 32'h10, 32'h0, 4'hF, r, e);
      check("rd10_data", r, 32'hDEADBEEF);
      check("rd10_err", 32'(e), 32'd0);

      // index wrap
      txn(1'b1, 32'h200, 32'h11223344, 4'hF, r, e);
      txn(1'b0, 32'h000, 32'h0, 4'hF, r, e);
      check("wrap_data", r, 32'h11223344);

      // reset aborts a pending write
      txn(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, r, e);
      aborted_write(32'h20, 32'h55555555);
      txn(1'b0, 32'h20, 32'h0, 4'hF, r, e);
      check("abort_keep", r, 32'hAAAAAAAA);

`ifdef DM_BYTEWR_EN
      txn(1'b1, 32'h30, 32'h0, 4'hF, r, e);
      txn(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0101, r, e);
      check("bw_err", 32'(e), 32'd0);
      txn(1'b0, 32'h30, 32'h0, 4'hF, r, e);
      check("bw_data", r, 32'h00FF00FF);
      txn(1'b1, 32'h30, 32'h12345678, 4'b0000, r, e);
      check("bw_zero_err", 32'(e), 32'd1);
      check("bw_zero_rdata", r, 32'd0);
      txn(1'b0, 32'h30, 32'h0, 4'hF, r, e);
      check("bw_keep", r, 32'h00FF00FF);
`else
      txn(1'b1, 32'h22, 32'h12345678, 4'hF, r, e);
      check("mis_wr_err", 32'(e), 32'd1);
      check("mis_wr_rdata", r, 32'd0);
      txn(1'b0, 32'h20, 32'h0, 4'hF, r, e);
      check("mis_keep", r, 32'hAAAAAAAA);
      txn(1'b0, 32'h21, 32'h0, 4'hF, r, e);
      check("mis_rd_err", 32'(e), 32'd1);
      check("mis_rd_rdata", r, 32'd0);
`endif

      // req held high: one acceptance per LAT+1 edges
      @(negedge clk);
      req = 1'b1; we = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, DEPTH - 1)) << 2; wdata = $urandom; be = 4'hF;
      n_rdy = 0;
      for (int i = 0; i < 3 * (LAT + 1); i++) begin
         @(posedge clk);
         #1;
         if (ready) n_rdy++;
      end
      req = 1'b0;
      check("cont_req_accepts", 32'(n_rdy), 32'd3);

      // random traffic
      repeat (300) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         d = $urandom;
         if ($urandom_range(0, 19) == 0) aborted_write({a[31:2], 2'b00}, d);
         else txn(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), r, e);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
